// File: rtl/contador_pkg.sv
// Shared constants for the contador_accion counter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: mode encodings for MODO and the fixed counter width.
package contador_pkg;

   localparam int WIDTH = 4;

   localparam logic [1:0] MODO_UP1  = 2'b00;
   localparam logic [1:0] MODO_DN1  = 2'b01;
   localparam logic [1:0] MODO_UP3  = 2'b10;
   localparam logic [1:0] MODO_LOAD = 2'b11;

endpackage

// File: rtl/sumador_mod16.sv
// Combinational mod-16 add of a 4-bit operand and a small signed step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever the inputs are.
//
// Ports:
//   a     - 4-bit unsigned operand (current count)
//   step  - 5-bit two's-complement step (+1, -1, +STEP3, or 0)
//   res   - {flag, sum[3:0]}; flag is the carry for positive steps and the
//           borrow for negative steps
import contador_pkg::*;

module sumador_mod16 (
   input  logic              [WIDTH-1:0] a,
   input  logic signed       [WIDTH:0]   step,
   output logic              [WIDTH:0]   res
);

   // The unwrapped result stays inside -1..18, so with a zero-extended operand
   // bit 4 is set both on overflow past 15 and on going below 0. That lets one
   // 5-bit adder report carry and borrow through the same bit.
   assign res = {1'b0, a} + $unsigned(step);

endmodule

// File: rtl/contador_accion.sv
// Mode-driven 4-bit counter producing the next count and a one-cycle wrap flag.
// Latency: 1 cycle from sampled inputs to Q / S_OUT / LOAD_ACK.
// Backpressure: none; ENB low holds the count and clears the pulse outputs.
//
// Ports:
//   CLK, RESET - clock and synchronous active-high reset
//   ENB        - count/load enable
//   MODO       - 00 up 1, 01 down 1, 10 up STEP3, 11 parallel load of D
//   D          - parallel load value
//   Q          - registered count
//   S_OUT      - registered wrap flag, one cycle per wrap
//   LOAD_ACK   - registered one-cycle pulse per accepted load
import contador_pkg::*;

module contador_accion #(
   parameter int WIDTH = contador_pkg::WIDTH,
   parameter int STEP3 = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENB,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             S_OUT,
   output logic             LOAD_ACK
);

   logic signed [WIDTH:0] step;
   logic        [WIDTH:0] suma;

   // Step selection for the single shared adder; the load mode does not use it.
   always_comb begin
      step = '0;
      case (MODO)
         MODO_UP1: step = (WIDTH+1)'(1);
         MODO_DN1: step = -(WIDTH+1)'(1);
         MODO_UP3: step = (WIDTH+1)'(STEP3);
         default:  step = '0;
      endcase
   end

   sumador_mod16 u_sumador (
      .a    (Q),
      .step (step),
      .res  (suma)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q        <= '0;
         S_OUT    <= 1'b0;
         LOAD_ACK <= 1'b0;
      end else if (!ENB) begin
         // Hold the count; a wrap that would have happened this cycle is dropped.
         S_OUT    <= 1'b0;
         LOAD_ACK <= 1'b0;
      end else if (MODO == MODO_LOAD) begin
         Q        <= D;
         S_OUT    <= 1'b0;
         LOAD_ACK <= 1'b1;
      end else begin
         Q        <= suma[WIDTH-1:0];
         S_OUT    <= suma[WIDTH];
         LOAD_ACK <= 1'b0;
      end
   end

endmodule

// File: tb/tb_contador_accion.sv
// Scoreboard bench for contador_accion: directed sequences plus random traffic.
// Latency: expectations are checked one clock after the inputs are applied.
// Backpressure: not applicable; the DUT answers every cycle.
module tb_contador_accion;

   logic       CLK;
   logic       RESET;
   logic       ENB;
   logic [1:0] MODO;
   logic [3:0] D;
   logic [3:0] Q;
   logic       S_OUT;
   logic       LOAD_ACK;

   contador_accion dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .ENB      (ENB),
      .MODO     (MODO),
      .D        (D),
      .Q        (Q),
      .S_OUT    (S_OUT),
      .LOAD_ACK (LOAD_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] q;
      logic       s;
      logic       ack;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state: plain integer count.
   int   m_q = 0;

   // Apply one cycle of stimulus and predict the response from the mode rules.
   task automatic cyc(input logic rst, input logic enb, input logic [1:0] modo,
                      input logic [3:0] d);
      exp_t e;
      int   n;
      @(negedge CLK);
      RESET = rst;
      ENB   = enb;
      MODO  = modo;
      D     = d;
      e.s   = 1'b0;
      e.ack = 1'b0;
      if (rst) begin
         m_q = 0;
      end else if (enb) begin
         case (modo)
            2'd0: begin n = m_q + 1; e.s = (n > 15); m_q = n % 16; end
            2'd1: begin n = m_q - 1; e.s = (n < 0);  m_q = (n + 16) % 16; end
            2'd2: begin n = m_q + 3; e.s = (n > 15); m_q = n % 16; end
            default: begin m_q = int'(d); e.ack = 1'b1; end
         endcase
      end
      e.q = 4'(m_q);
      sb.push_back(e);
   endtask

   // Monitor: after each rising edge, compare the DUT against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (Q !== e.q) begin
               fails++;
               $display("FAIL q: got %0d expected %0d at %0t", Q, e.q, $time);
            end
            tests++;
            if (S_OUT !== e.s) begin
               fails++;
               $display("FAIL s_out: got %0b expected %0b (q=%0d) at %0t", S_OUT, e.s, Q, $time);
            end
            tests++;
            if (LOAD_ACK !== e.ack) begin
               fails++;
               $display("FAIL load_ack: got %0b expected %0b at %0t", LOAD_ACK, e.ack, $time);
            end
         end
      end
   end

   initial begin
      RESET = 1'b1;
      ENB   = 1'b0;
      MODO  = 2'd0;
      D     = 4'd0;

      // Reset state, then 17 up-by-1 steps across the wrap.
      cyc(1'b1, 1'b0, 2'd0, 4'd0);
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 2'd0, 4'd0);

      // Load 2, then count down through the 0 -> 15 wrap.
      cyc(1'b0, 1'b1, 2'd3, 4'h2);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd1, 4'd0);

      // Load 13, then step by 3 across the wrap.
      cyc(1'b0, 1'b1, 2'd3, 4'd13);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd2, 4'd0);

      // Reach 7, hold three cycles, re-enable.
      cyc(1'b0, 1'b1, 2'd3, 4'd6);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, 4'd0);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);

      // Hold while a wrap would occur: count sits at 15.
      cyc(1'b0, 1'b1, 2'd3, 4'd15);
      cyc(1'b0, 1'b0, 2'd0, 4'd0);

      // Reset at 15 with enable high suppresses the wrap; resume from 0.
      cyc(1'b1, 1'b1, 2'd0, 4'd0);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);

      // Reset overrides a pending load.
      cyc(1'b1, 1'b1, 2'd3, 4'd9);

      // Alternate down/up at the 0/15 boundary: back-to-back wraps.
      cyc(1'b0, 1'b1, 2'd1, 4'd0);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);
      cyc(1'b0, 1'b1, 2'd1, 4'd0);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);

      // Consecutive loads pulse LOAD_ACK every cycle.
      cyc(1'b0, 1'b1, 2'd3, 4'd5);
      cyc(1'b0, 1'b1, 2'd3, 4'd14);
      cyc(1'b0, 1'b1, 2'd2, 4'd0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 39) == 0),
             ($urandom_range(0, 4) != 0),
             2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)));
      end

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d predictions left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
